// File: rtl/dmem_responder.sv
// dmem_responder
//   Memory-side end of the MEM-stage load/store interface. It accepts one
//   request at a time through a valid/ready handshake. Each request gets an
//   answer after LATENCY clock edges, so the pipeline sees a real multi-cycle
//   memory and the hazard/stall logic gets exercised.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words held (word index 0..DEPTH_WORDS-1)
//   LATENCY     : edges from request acceptance to response strobe (1..255)
//
// Ports
//   clk, reset  : clock; synchronous active-high reset (also clears storage)
//   req_valid   : request present (requester holds it until accepted)
//   req_write   : 1 = store, 0 = load
//   req_addr    : byte address, word index = req_addr[31:2]
//   req_wdata   : store data
//   req_ready   : block is idle and can accept a request this cycle
//   resp_valid  : one-cycle response strobe
//   resp_rdata  : load data / store echo / 0 on error (held between responses)
//   resp_err    : misaligned or out-of-range access (held between responses)
module dmem_responder #(
    parameter int DEPTH_WORDS = 16384,
    parameter int LATENCY     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    state_t           state, state_nxt;
    logic [7:0]       cnt;
    req_t             req_q;
    logic [31:0]      mem [DEPTH_WORDS];

    logic             accept;
    logic             access;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;

    assign req_ready  = (state == IDLE) && !reset;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == RESP);

    // Every request, including LATENCY == 1, passes through BUSY. The counter
    // starts at LATENCY-1, and the access happens on the edge that leaves BUSY
    // with the counter at 0. This puts the strobe exactly LATENCY edges after
    // the accepting edge. When LATENCY == 1, BUSY lasts a single cycle with the
    // counter already at 0.
    assign access  = (state == BUSY) && (cnt == 8'd0);
    assign acc_err = (req_q.addr[1:0] != 2'b00) ||
                     ({2'b00, req_q.addr[31:2]} >= 32'(DEPTH_WORDS));
    assign acc_idx = req_q.addr[IDX_W+1:2];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (cnt == 8'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= 8'd0;
            req_q      <= '0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                req_q <= '{write: req_write, addr: req_addr, wdata: req_wdata};
                cnt   <= CNT_INIT;
            end else if ((state == BUSY) && (cnt != 8'd0)) begin
                cnt <= cnt - 8'd1;
            end
            // The response fields change only at the access, so they hold
            // steady until the next response.
            if (access) begin
                resp_err   <= acc_err;
                resp_rdata <= acc_err     ? 32'd0       :
                              req_q.write ? req_q.wdata : mem[acc_idx];
            end
        end
    end

    // Storage: reset clears it, and it is written only by non-error stores at
    // their access edge. A reset during BUSY therefore drops the store.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= 32'd0;
        end else if (access && req_q.write && !acc_err) begin
            mem[acc_idx] <= req_q.wdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;

    // dut A: LATENCY=4, default depth
    logic        a_valid, a_write, a_ready, a_rv, a_err;
    logic [31:0] a_addr, a_wdata, a_rd;
    // dut B: LATENCY=1, small depth
    logic        b_valid, b_write, b_ready, b_rv, b_err;
    logic [31:0] b_addr, b_wdata, b_rd;

    int n_chk  = 0;
    int n_pass = 0;

    localparam int DEPTH_A = 16384;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH_A), .LATENCY(4)) u_a (
        .clk(clk), .reset(reset),
        .req_valid(a_valid), .req_write(a_write), .req_addr(a_addr), .req_wdata(a_wdata),
        .req_ready(a_ready), .resp_valid(a_rv), .resp_rdata(a_rd), .resp_err(a_err)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) u_b (
        .clk(clk), .reset(reset),
        .req_valid(b_valid), .req_write(b_write), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .resp_valid(b_rv), .resp_rdata(b_rd), .resp_err(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic drive(input int sel, input logic v, input logic w,
                         input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            a_valid = v; a_write = w; a_addr = addr; a_wdata = wd;
        end else begin
            b_valid = v; b_write = w; b_addr = addr; b_wdata = wd;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? a_ready : b_ready;
    endfunction
    function automatic logic get_rv(input int sel);
        return (sel == 0) ? a_rv : b_rv;
    endfunction
    function automatic logic get_err(input int sel);
        return (sel == 0) ? a_err : b_err;
    endfunction
    function automatic logic [31:0] get_rd(input int sel);
        return (sel == 0) ? a_rd : b_rd;
    endfunction

    // One full transaction from idle: accept at E0, strobe right after E_lat,
    // ready again right after E_lat+1. In noise mode a different store is
    // presented with valid high throughout BUSY, and it must be ignored.
    task automatic txn(input int sel, input logic w, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input bit noise, input string tag);
        int lat;
        lat = (sel == 0) ? 4 : 1;
        chk({tag, "_ready_pre"}, 32'(get_ready(sel)), 32'd1);
        drive(sel, 1'b1, w, addr, wd);
        step();  // E0: accepted
        if (noise) drive(sel, 1'b1, 1'b1, addr ^ 32'h60, 32'hBAD0BAD0);
        else       drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int k = 1; k <= lat; k++) begin
            step();
            chk($sformatf("%s_rv_E%0d", tag, k), 32'(get_rv(sel)), (k == lat) ? 32'd1 : 32'd0);
            chk($sformatf("%s_ready_E%0d", tag, k), 32'(get_ready(sel)), 32'd0);
            if (k == lat) begin
                chk({tag, "_rdata"}, get_rd(sel), exp_rd);
                chk({tag, "_err"}, 32'(get_err(sel)), 32'(exp_err));
                drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        step();
        chk({tag, "_rv_post"}, 32'(get_rv(sel)), 32'd0);
        chk({tag, "_ready_post"}, 32'(get_ready(sel)), 32'd1);
        chk({tag, "_rdata_hold"}, get_rd(sel), exp_rd);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        step(); step();
        chk("rst_ready_a", 32'(a_ready), 32'd0);
        chk("rst_ready_b", 32'(b_ready), 32'd0);
        chk("rst_rv_a", 32'(a_rv), 32'd0);
        chk("rst_rdata_a", a_rd, 32'd0);
        chk("rst_err_a", 32'(a_err), 32'd0);
        // A request presented during reset must not be accepted.
        drive(0, 1'b1, 1'b1, 32'h10, 32'h77);
        step();
        chk("rst_noaccept_ready", 32'(a_ready), 32'd0);
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        #1;
        chk("rel_ready_a", 32'(a_ready), 32'd1);
        chk("rel_ready_b", 32'(b_ready), 32'd1);

        // LATENCY=4 block
        txn(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0, "ld10");
        txn(0, 1'b1, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 0, "st20");
        txn(0, 1'b0, 32'h20, 32'h0, 32'hDEADBEEF, 1'b0, 0, "ld20");
        txn(0, 1'b1, 32'(DEPTH_A*4 - 4), 32'h12345678, 32'h12345678, 1'b0, 0, "st_last");
        txn(0, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 0, "ld_misal");
        txn(0, 1'b1, 32'(DEPTH_A*4), 32'hCAFEF00D, 32'h0, 1'b1, 0, "st_oor");
        txn(0, 1'b0, 32'(DEPTH_A*4 - 4), 32'h0, 32'h12345678, 1'b0, 0, "ld_last");
        txn(0, 1'b1, 32'h30, 32'h55AA55AA, 32'h55AA55AA, 1'b0, 1, "st30_noise");
        txn(0, 1'b0, 32'h30, 32'h0, 32'h55AA55AA, 1'b0, 0, "ld30");
        txn(0, 1'b0, 32'h50, 32'h0, 32'h0, 1'b0, 0, "ld50_untouched");

        // Reset while a store to 0x40 is in BUSY: the store is dropped and no strobe appears.
        drive(0, 1'b1, 1'b1, 32'h40, 32'h1234);
        step();
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        step(); step();
        chk("abort_busy_ready", 32'(a_ready), 32'd0);
        reset = 1'b1;
        step();
        chk("abort_rv_in_rst", 32'(a_rv), 32'd0);
        chk("abort_ready_in_rst", 32'(a_ready), 32'd0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("abort_rv_after_%0d", k), 32'(a_rv), 32'd0);
        end
        chk("abort_rdata_cleared", a_rd, 32'd0);
        txn(0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0, 0, "ld40_after_abort");
        txn(0, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 0, "ld20_cleared");

        // LATENCY=1 block: alternating store/load pairs, then a readback sweep.
        for (int i = 0; i < 8; i++) begin
            txn(1, 1'b1, 32'(i*4), 32'hA5000000 + 32'(i)*32'h01010101,
                32'hA5000000 + 32'(i)*32'h01010101, 1'b0, 0, $sformatf("b_st%0d", i));
            txn(1, 1'b0, 32'(i*4), 32'h0,
                32'hA5000000 + 32'(i)*32'h01010101, 1'b0, 0, $sformatf("b_ld%0d", i));
        end
        for (int i = 0; i < 8; i++)
            txn(1, 1'b0, 32'(i*4), 32'h0,
                32'hA5000000 + 32'(i)*32'h01010101, 1'b0, 0, $sformatf("b_rb%0d", i));
        txn(1, 1'b0, 32'(64*4), 32'h0, 32'h0, 1'b1, 0, "b_oor");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
